// File: rtl/frame_capture.sv
// ---------------------------------------------------------------------------
// frame_capture
//
// Camera-side writer for the frame buffer BRAM. Samples an OV7670-style
// parallel bus running RGB444 with two bytes per pixel, assembles 12-bit
// {R,G,B} pixels and writes them row-major at address row*IMAGE_WIDTH+col.
// The downstream red-object detector reads R from [11:8], G from [7:4] and
// B from [3:0].
//
// Ports
//   clk         camera pixel clock (PCLK), all logic on its rising edge
//   reset       synchronous, active-high
//   vsync       frame sync, high between frames
//   href        line valid, high while pixel bytes are on d
//   d[7:0]      camera data byte
//   wraddress   BRAM write address (ADDR_BITS wide)
//   wrdata      pixel {R[3:0],G[3:0],B[3:0]}
//   wren        BRAM write enable, one cycle per pixel
//   frame_done  one-cycle pulse at the end of each captured frame
//   frame_ok    level: last completed frame had exactly W*H pixels written
// ---------------------------------------------------------------------------
module frame_capture #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int ADDR_BITS    = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vsync,
    input  logic                 href,
    input  logic [7:0]           d,
    output logic [ADDR_BITS-1:0] wraddress,
    output logic [11:0]          wrdata,
    output logic                 wren,
    output logic                 frame_done,
    output logic                 frame_ok
);

    // Counters are one value wider than the visible range so they can hold
    // their saturation value (IMAGE_WIDTH, IMAGE_HEIGHT, W*H).
    localparam int COL_BITS = $clog2(IMAGE_WIDTH + 1);
    localparam int ROW_BITS = $clog2(IMAGE_HEIGHT + 1);
    localparam int CTR_BITS = ADDR_BITS + 1;

    localparam logic [COL_BITS-1:0] COL_LIMIT   = COL_BITS'(IMAGE_WIDTH);
    localparam logic [ROW_BITS-1:0] ROW_LIMIT   = ROW_BITS'(IMAGE_HEIGHT);
    localparam logic [CTR_BITS-1:0] PIXEL_COUNT = CTR_BITS'(IMAGE_WIDTH * IMAGE_HEIGHT);

    typedef enum logic [1:0] {
        WAIT_VSYNC,
        WAIT_START,
        CAPTURE
    } state_t;

    state_t              state;
    logic                vsync_q;
    logic                href_q;
    logic                href_d;
    logic [7:0]          d_q;
    logic                byte_phase;
    logic [3:0]          r_nib;
    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] row;
    logic [CTR_BITS-1:0] addr_ctr;

    // The camera bus is registered once before the FSM looks at it, so a
    // byte sampled on edge N produces its write on edge N+1. href_d is the
    // previous registered href, used to find the end of a line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WAIT_VSYNC;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            href_d     <= 1'b0;
            d_q        <= '0;
            byte_phase <= 1'b0;
            r_nib      <= '0;
            col        <= '0;
            row        <= '0;
            addr_ctr   <= '0;
            wraddress  <= '0;
            wrdata     <= '0;
            wren       <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments everywhere in this block, so
            // every right-hand side reads the value from before this edge.
            vsync_q <= vsync;
            href_q  <= href;
            d_q     <= d;
            href_d  <= href_q;

            // NOTE: pulse outputs default low here and are raised below only
            // on the cycle that needs them, which keeps them one cycle wide.
            wren       <= 1'b0;
            frame_done <= 1'b0;

            case (state)
                WAIT_VSYNC: begin
                    // Whatever frame was running at power-up is ignored until
                    // a full vsync high->low sequence is seen.
                    if (vsync_q) begin
                        state <= WAIT_START;
                    end
                end

                WAIT_START: begin
                    if (!vsync_q) begin
                        col        <= '0;
                        row        <= '0;
                        addr_ctr   <= '0;
                        byte_phase <= 1'b0;
                        state      <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    if (vsync_q) begin
                        // vsync has priority over a byte on the same cycle.
                        frame_done <= 1'b1;
                        frame_ok   <= (addr_ctr == PIXEL_COUNT);
                        state      <= WAIT_START;
                    end else if (href_q) begin
                        byte_phase <= ~byte_phase;
                        if (!byte_phase) begin
                            r_nib <= d_q[3:0];
                        end else if (col < COL_LIMIT) begin
                            // Pixels past the last row still advance col but
                            // never reach the BRAM.
                            col <= col + 1'b1;
                            if (row < ROW_LIMIT) begin
                                wren      <= 1'b1;
                                wrdata    <= {r_nib, d_q};
                                wraddress <= addr_ctr[ADDR_BITS-1:0];
                                addr_ctr  <= addr_ctr + 1'b1;
                            end
                        end
                    end else if (href_d) begin
                        // End of line: a dangling first byte is dropped by
                        // forcing the phase back to the first byte.
                        if (row < ROW_LIMIT) begin
                            row <= row + 1'b1;
                        end
                        col        <= '0;
                        byte_phase <= 1'b0;
                    end
                end

                default: begin
                    state <= WAIT_VSYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_capture.sv
// ---------------------------------------------------------------------------
// tb_frame_capture
//
// Directed bench for frame_capture with a 4x2 image. Each tick drives one
// set of camera inputs, waits for the rising edge and looks at the outputs
// 1 ns later; writes and frame_done pulses seen on any tick are collected
// so whole lines can be compared against hand-computed pixels afterwards.
// ---------------------------------------------------------------------------
module tb_frame_capture;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AB = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          vsync;
    logic          href;
    logic [7:0]    d;
    logic [AB-1:0] wraddress;
    logic [11:0]   wrdata;
    logic          wren;
    logic          frame_done;
    logic          frame_ok;

    typedef struct {
        logic [AB-1:0] addr;
        logic [11:0]   data;
    } wr_t;

    wr_t wq[$];
    int  n_assert = 0;
    int  n_fail   = 0;
    int  fd_count = 0;

    frame_capture #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .ADDR_BITS   (AB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .vsync     (vsync),
        .href      (href),
        .d         (d),
        .wraddress (wraddress),
        .wrdata    (wrdata),
        .wren      (wren),
        .frame_done(frame_done),
        .frame_ok  (frame_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pixel content for line "seed", pixel p. seed < 0 is the fixed 0xABC
    // pattern sent as byte pairs (0x0A, 0xBC).
    function automatic logic [11:0] px(input int seed, input int p);
        logic [3:0] r, g, b;
        if (seed < 0) return 12'hABC;
        r = 4'(seed * 3 + p);
        g = 4'(seed + 2 * p + 5);
        b = 4'(seed * 7 + p * 3 + 1);
        return {r, g, b};
    endfunction

    // First byte carries junk in [7:4] which the DUT must ignore.
    function automatic logic [7:0] first_byte(input int seed, input int p);
        logic [11:0] v;
        v = px(seed, p);
        return {4'(seed + p + 9), v[11:8]};
    endfunction

    function automatic logic [7:0] second_byte(input int seed, input int p);
        logic [11:0] v;
        v = px(seed, p);
        return v[7:0];
    endfunction

    task automatic tick(input logic rs, input logic vs, input logic hr, input logic [7:0] dd);
        reset = rs;
        vsync = vs;
        href  = hr;
        d     = dd;
        @(posedge clk);
        #1;
        if (wren === 1'b1) wq.push_back('{addr: wraddress, data: wrdata});
        if (frame_done === 1'b1) fd_count++;
    endtask

    task automatic frame_start();
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame_end();
        repeat (3) tick(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic send_line(input int nbytes, input int seed);
        for (int i = 0; i < nbytes; i++) begin
            if (i % 2 == 0) tick(1'b0, 1'b0, 1'b1, first_byte(seed, i / 2));
            else            tick(1'b0, 1'b0, 1'b1, second_byte(seed, i / 2));
        end
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Expect n writes at addresses 0..n-1; row 0 from seed s0, row 1 from s1.
    task automatic check_writes(input string tag, input int n, input int s0, input int s1);
        check({tag, "_count"}, wq.size(), n);
        for (int i = 0; i < n && i < wq.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wq[i].addr, i);
            check($sformatf("%s_data%0d", tag, i), wq[i].data, px((i < W) ? s0 : s1, i % W));
        end
        wq.delete();
    endtask

    initial begin
        // Reset values
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        check("rst_wren", wren, 0);
        check("rst_wrdata", wrdata, 0);
        check("rst_wraddress", wraddress, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_ok", frame_ok, 0);
        wq.delete();
        fd_count = 0;

        // Full 4x2 frame; first line checked cycle by cycle for latency
        frame_start();
        tick(1'b0, 1'b0, 1'b1, 8'h0A);
        tick(1'b0, 1'b0, 1'b1, 8'hBC);
        check("latency_early", wren, 0);
        tick(1'b0, 1'b0, 1'b1, 8'h0A);
        check("latency_wren", wren, 1);
        check("latency_addr", wraddress, 0);
        check("latency_data", wrdata, 12'hABC);
        tick(1'b0, 1'b0, 1'b1, 8'hBC);
        check("no_consecutive_wren", wren, 0);
        tick(1'b0, 1'b0, 1'b1, 8'h0A);
        tick(1'b0, 1'b0, 1'b1, 8'hBC);
        tick(1'b0, 1'b0, 1'b1, 8'h0A);
        tick(1'b0, 1'b0, 1'b1, 8'hBC);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        send_line(8, 2);
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        check("fd_early", frame_done, 0);
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        check("fd_pulse", frame_done, 1);
        check("full_frame_ok", frame_ok, 1);
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        check("fd_width", frame_done, 0);
        check_writes("full", 8, -1, 2);
        check("full_fd_count", fd_count, 1);

        // Long line: 12 bytes, only 4 written, next line starts at addr 4
        fd_count = 0;
        frame_start();
        send_line(12, 3);
        send_line(8, 4);
        frame_end();
        check_writes("long", 8, 3, 4);
        check("long_frame_ok", frame_ok, 1);
        check("long_fd_count", fd_count, 1);

        // Short frame: one line only
        fd_count = 0;
        frame_start();
        send_line(8, 5);
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        check("short_ok_held", frame_ok, 1);
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        check("short_fd", frame_done, 1);
        check("short_frame_ok", frame_ok, 0);
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        check_writes("short", 4, 5, 0);
        check("short_fd_count", fd_count, 1);

        // Odd byte count: 9th byte dropped, next line assembles cleanly
        fd_count = 0;
        frame_start();
        send_line(9, 6);
        send_line(8, 7);
        frame_end();
        check_writes("odd", 8, 6, 7);
        check("odd_frame_ok", frame_ok, 1);

        // Reset mid-line drops the in-flight write
        frame_start();
        tick(1'b0, 1'b0, 1'b1, first_byte(11, 0));
        tick(1'b0, 1'b0, 1'b1, second_byte(11, 0));
        tick(1'b1, 1'b0, 1'b1, first_byte(11, 1));
        check("midrst_wren", wren, 0);
        check("midrst_frame_ok", frame_ok, 0);
        check("midrst_frame_done", frame_done, 0);
        check("midrst_dropped", wq.size(), 0);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        send_line(8, 12);
        send_line(8, 12);
        check("no_capture_before_vsync", wq.size(), 0);
        wq.delete();
        fd_count = 0;
        frame_start();
        send_line(8, 8);
        send_line(8, 9);
        frame_end();
        check_writes("restart", 8, 8, 9);
        check("restart_frame_ok", frame_ok, 1);
        check("restart_fd_count", fd_count, 1);

        // vsync rises on the second byte of a pixel while href is high
        fd_count = 0;
        frame_start();
        send_line(8, 10);
        tick(1'b0, 1'b0, 1'b1, first_byte(13, 0));
        tick(1'b0, 1'b1, 1'b1, second_byte(13, 0));
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        check_writes("vs_race", 4, 10, 0);
        check("vs_race_fd_count", fd_count, 1);
        check("vs_race_frame_ok", frame_ok, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
